arbiter2_leaf: RTL
==================

ARBITER2_LEAF -- requirements
Module: arbiter2_leaf

Interface
REQ-001 Parameter W, default 9: flit width in bits; bit W-1 is the tail marker (1 = last flit of packet).
REQ-002 CLK  input  1  single clock; all state changes on rising edge.
REQ-003 _RESET  input  1  reset, asynchronous assert, active-low.
REQ-004 in0_data  input  W  flit from source 0.
REQ-005 in0_valid  input  1  source 0 flit present.
REQ-006 in0_ready  output  1  arbiter accepts source 0 flit this cycle.
REQ-007 in1_data / in1_valid / in1_ready: same as REQ-004..006, for source 1.
REQ-008 out_data  output  W  merged flit stream.
REQ-009 out_valid  output  1  out_data holds a flit.
REQ-010 out_ready  input  1  downstream accepts the flit.
REQ-011 s_data  output  1  index of the source granted for a packet.
REQ-012 s_valid  output  1  s_data holds a grant token.
REQ-013 s_ready  input  1  downstream accepts the grant token.

Function
REQ-014 The block SHALL merge packets from two sources onto Out and emit one S token per packet carrying the source index, as the inverse of the 2-way decoder leaf.
REQ-015 A transfer SHALL occur on any channel in a cycle where valid and ready are both 1 at the rising edge.
REQ-016 The FSM SHALL have states IDLE, LOCK0, LOCK1.
REQ-017 In IDLE, a head flit from source n SHALL be accepted only when the Out buffer holds fewer than 2 flits and the S buffer holds fewer than 2 tokens; acceptance pushes the flit to Out and the value n to S in the same cycle.
REQ-018 In IDLE with both valid, the grant SHALL go to the source indicated by a priority pointer; with one valid, that source is granted regardless of the pointer.
REQ-019 An accepted head flit with tail=0 SHALL move the FSM to LOCKn; an accepted head flit with tail=1 (single-flit packet) SHALL keep the FSM in IDLE.
REQ-020 In LOCKn, in_n_ready SHALL equal (Out count < 2), the other source's ready SHALL be 0, and S buffer occupancy SHALL NOT gate acceptance.
REQ-021 Acceptance of a tail flit in LOCKn SHALL return the FSM to IDLE.
REQ-022 On every packet completion (tail accepted), the priority pointer SHALL point to the source other than the one just served.
REQ-023 in_ready SHALL depend only on registered state and the in_valid inputs, never combinationally on out_ready or s_ready.
REQ-024 A flit accepted at edge N SHALL be presented on out_data with out_valid=1 from edge N onward (one-cycle latency), in acceptance order.
REQ-025 With out_ready held at 1, Out throughput SHALL be one flit per cycle.
REQ-026 A simultaneous push and pop on the Out or S buffer SHALL leave its count unchanged; a full buffer SHALL refuse pushes even if a pop occurs in the same cycle.
REQ-027 out_data and s_data SHALL hold stable while valid=1 and ready=0.

Reset
REQ-028 While _RESET=0: out_valid=0, s_valid=0, out_data=0, s_data=0, in0_ready=0, in1_ready=0, FSM=IDLE, pointer=source 0, both buffers empty.
REQ-029 Reset asserted mid-packet SHALL discard all buffered flits and tokens and the partial packet lock without emitting further output.

Structure
REQ-030 Shared package noc_pkg SHALL hold FLIT_W=9, TAIL_BIT=FLIT_W-1, and the FSM state enum typedef.
REQ-031 One sub-module, fifo2 (2-entry synchronous FIFO, parameterised width, registered valid, count output), SHALL be instantiated twice: Out buffer (W) and S buffer (1).

Verification
REQ-032 Single source: in0 sends flits 0x011, 0x012, 0x113 (tail), out_ready=1 -> out emits the same three in order, one cycle after each acceptance; s emits one token, 0.
REQ-033 Contention: both sources present 1-flit packets (0x1AA from in0, 0x1BB from in1) every cycle after reset -> out alternates 0x1AA, 0x1BB, ...; s alternates 0,1,...
REQ-034 Lock: in0 starts a 4-flit packet, in1 valid throughout -> in1_ready=0 until in0 tail is accepted; no in1 flit is interleaved.
REQ-035 Backpressure: out_ready=0 for 5 cycles -> exactly 2 flits accepted, in_ready=0 afterwards, data stable; releasing out_ready drains with no loss or duplication.
REQ-036 S stall: s_ready=0, three 1-flit packets offered -> only 2 accepted; a multi-flit packet already locked continues to flow.
REQ-037 Reset mid-packet after 2 of 4 flits -> all outputs 0 next edge; after release, a new packet from in1 is granted first only if in0 is idle (pointer=0).

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit geometry and the arbiter leaf FSM encoding.
package noc_pkg;

  localparam int unsigned FLIT_W   = 9;
  localparam int unsigned TAIL_BIT = FLIT_W - 1;

  typedef enum logic [1:0] {
    StIdle,
    StLock0,
    StLock1
  } arb_state_e;

endpackage

// File: rtl/fifo2.sv
// Two-entry synchronous FIFO with registered valid and occupancy count.
// A push into a full FIFO is dropped even when a pop happens in the same cycle.
module fifo2 #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  input  logic [Width-1:0] in_data_i,
  output logic             out_valid_o,
  output logic [Width-1:0] out_data_o,
  input  logic             out_ready_i,
  output logic [1:0]       count_o
);

  logic [Width-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       cnt_q, cnt_d;
  logic             valid_q;
  logic             push;
  logic             pop;

  always_comb begin
    push  = in_valid_i && (cnt_q != 2'd2);
    pop   = out_ready_i && valid_q;
    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + 2'd1;
    end else if (!push && pop) begin
      cnt_d = cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
      valid_q  <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= in_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q   <= cnt_d;
      valid_q <= (cnt_d != 2'd0);
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = mem_q[rd_ptr_q];
  assign count_o     = cnt_q;

endmodule

// File: rtl/arbiter2_leaf.sv
// Two-input packet arbiter leaf: merges packets onto one flit stream and emits one
// source-index token per packet. A packet holds the grant until its tail flit.
module arbiter2_leaf
  import noc_pkg::*;
#(
  parameter int unsigned W = FLIT_W
) (
  input  logic         CLK,
  input  logic         _RESET,
  input  logic [W-1:0] in0_data,
  input  logic         in0_valid,
  output logic         in0_ready,
  input  logic [W-1:0] in1_data,
  input  logic         in1_valid,
  output logic         in1_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         s_data,
  output logic         s_valid,
  input  logic         s_ready
);

  arb_state_e   state_q, state_d;
  logic         ptr_q, ptr_d;
  logic         active_q;
  logic [1:0]   out_cnt;
  logic [1:0]   s_cnt;
  logic         out_room;
  logic         s_room;
  logic         fire0;
  logic         fire1;
  logic         out_push;
  logic [W-1:0] out_push_data;
  logic         s_push;

  assign out_room = (out_cnt < 2'd2);
  assign s_room   = (s_cnt < 2'd2);

  // active_q keeps both readies low during reset and the first cycle after release.
  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) begin
      state_q  <= StIdle;
      ptr_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      active_q <= 1'b1;
    end
  end

  always_comb begin
    in0_ready = 1'b0;
    in1_ready = 1'b0;
    state_d   = state_q;
    ptr_d     = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (active_q && out_room && s_room) begin
          in0_ready = !in1_valid || !ptr_q;
          in1_ready = !in0_valid || ptr_q;
        end
      end
      StLock0: in0_ready = out_room;
      StLock1: in1_ready = out_room;
      default: ;
    endcase

    fire0 = in0_valid && in0_ready;
    fire1 = in1_valid && in1_ready;

    if (fire0) begin
      if (in0_data[W-1]) begin
        state_d = StIdle;
        ptr_d   = 1'b1;
      end else begin
        state_d = StLock0;
      end
    end else if (fire1) begin
      if (in1_data[W-1]) begin
        state_d = StIdle;
        ptr_d   = 1'b0;
      end else begin
        state_d = StLock1;
      end
    end
  end

  assign out_push      = fire0 || fire1;
  assign out_push_data = fire1 ? in1_data : in0_data;
  // Only head flits (accepted in idle) produce a grant token.
  assign s_push        = out_push && (state_q == StIdle);

  fifo2 #(
    .Width(W)
  ) u_out_buf (
    .clk_i      (CLK),
    .rst_ni     (_RESET),
    .in_valid_i (out_push),
    .in_data_i  (out_push_data),
    .out_valid_o(out_valid),
    .out_data_o (out_data),
    .out_ready_i(out_ready),
    .count_o    (out_cnt)
  );

  fifo2 #(
    .Width(1)
  ) u_s_buf (
    .clk_i      (CLK),
    .rst_ni     (_RESET),
    .in_valid_i (s_push),
    .in_data_i  (fire1),
    .out_valid_o(s_valid),
    .out_data_o (s_data),
    .out_ready_i(s_ready),
    .count_o    (s_cnt)
  );

endmodule
